wta_arbiter: RTL and testbench

WTA_ARBITER -- requirements
Module: wta_arbiter

---
 rtl/wta_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_wta_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wta_arbiter.sv
// wta_arbiter: winner-take-all arbiter for a layer of N spiking output neurons.
//
// One frame runs as follows. Wait until every neuron has reported end of
// accumulation (valid_pp3m). Scan the potentials one per cycle to find the
// signed maximum. Release the neurons with start_pp3m, and tell them through
// won_lost_hold which of them may fire. Collect the final spike flags
// (valid_pp3 / spike_pp). Publish the flags on spike_out. If anything fired,
// raise the adaptive threshold.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   start_core_img      new-image abort; wins over everything, keeps threshold/spike_out
//   potential_flat      N signed Q.12 potentials, neuron i at [W*i +: W]
//   valid_pp3m          per-neuron "accumulation finished" pulses
//   valid_pp3, spike_pp per-neuron "final update done" pulses and spike flags
//   start_pp3m          1-cycle release pulse (DECIDE)
//   valid_maxing        1-cycle "threshold valid" pulse (DECIDE)
//   won_lost_hold       one-hot winner, or all ones when nobody beats the threshold
//   threshold           current signed firing threshold
//   winner_idx          argmax of the last scan
//   spike_out           spike flags of the last completed frame
//   frame_done          1-cycle frame completion pulse

// Per-neuron handshake bookkeeping: seen (pp3m), done (pp3) and the captured spike.
module wta_lane (
  input  logic clk,
  input  logic rst,
  input  logic abort,
  input  logic seen_ld,
  input  logic seen_acc,
  input  logic done_clr,
  input  logic done_acc,
  input  logic valid_pp3m,
  input  logic valid_pp3,
  input  logic spike_pp,
  output logic seen,
  output logic done,
  output logic spike_acc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen      <= 1'b0;
      done      <= 1'b0;
      spike_acc <= 1'b0;
    end else if (abort) begin
      seen      <= 1'b0;
      done      <= 1'b0;
      spike_acc <= 1'b0;
    end else begin
      // IDLE reloads: this clears the previous frame and records a first pulse together
      if (seen_ld)       seen <= valid_pp3m;
      else if (seen_acc) seen <= seen | valid_pp3m;
      if (done_clr) begin
        done      <= 1'b0;
        spike_acc <= 1'b0;
      end else if (done_acc && valid_pp3) begin
        done      <= 1'b1;
        spike_acc <= spike_pp;
      end
    end
  end
endmodule

module wta_arbiter #(
  parameter int N       = 8,
  parameter int W       = 32,
  parameter int TH_INIT = 15019,
  parameter int TH_INC  = 205,
  parameter int TH_MAX  = 32768,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_core_img,
  input  logic [N*W-1:0]      potential_flat,
  input  logic [N-1:0]        valid_pp3m,
  input  logic [N-1:0]        valid_pp3,
  input  logic [N-1:0]        spike_pp,
  output logic                start_pp3m,
  output logic [N-1:0]        won_lost_hold,
  output logic                valid_maxing,
  output logic signed [W-1:0] threshold,
  output logic [IW-1:0]       winner_idx,
  output logic [N-1:0]        spike_out,
  output logic                frame_done
);
  typedef enum logic [2:0] {IDLE, COLLECT, SCAN, DECIDE, WAIT_PP3, DONE} state_t;

  typedef struct packed {
    logic signed [W-1:0] val;
    logic [IW-1:0]       idx;
  } max_t;

  localparam logic signed [W:0] TH_INC_X = (W+1)'(TH_INC);
  localparam logic signed [W:0] TH_MAX_X = (W+1)'(TH_MAX);

  state_t               state;
  logic [N-1:0]         seen_mask, done_mask, spike_acc;
  logic [N-1:0][W-1:0]  pot;
  logic [IW-1:0]        scan_cnt;
  max_t                 run_max, cand;
  logic signed [W-1:0]  cur_pot;
  logic [N-1:0]         cand_onehot;
  logic signed [W:0]    th_sum;
  logic signed [W-1:0]  th_next;
  logic                 start_q, vmax_q, fdone_q;

  assign pot     = potential_flat;
  assign cur_pot = pot[scan_cnt];

  // Running max including the neuron under scan. Index 0 seeds the max. Strict
  // greater keeps the lowest index on a tie.
  always_comb begin
    cand        = run_max;
    cand_onehot = '0;
    if (scan_cnt == '0 || cur_pot > run_max.val) begin
      cand.val = cur_pot;
      cand.idx = scan_cnt;
    end
    cand_onehot[cand.idx] = 1'b1;
  end

  // Sign-extend to W+1 bits so the increment can never wrap before saturation
  always_comb begin
    th_sum  = {threshold[W-1], threshold} + TH_INC_X;
    th_next = (th_sum > TH_MAX_X) ? TH_MAX_X[W-1:0] : th_sum[W-1:0];
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    wta_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .abort      (start_core_img),
      .seen_ld    (state == IDLE),
      .seen_acc   (state == COLLECT),
      .done_clr   (state == DECIDE),
      .done_acc   (state == WAIT_PP3),
      .valid_pp3m (valid_pp3m[i]),
      .valid_pp3  (valid_pp3[i]),
      .spike_pp   (spike_pp[i]),
      .seen       (seen_mask[i]),
      .done       (done_mask[i]),
      .spike_acc  (spike_acc[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      scan_cnt      <= '0;
      run_max       <= '0;
      threshold     <= W'(TH_INIT);
      won_lost_hold <= '1;
      winner_idx    <= '0;
      spike_out     <= '0;
      start_q       <= 1'b0;
      vmax_q        <= 1'b0;
      fdone_q       <= 1'b0;
    end else begin
      start_q <= 1'b0;
      vmax_q  <= 1'b0;
      fdone_q <= 1'b0;
      if (start_core_img) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:     if (|valid_pp3m) state <= COLLECT;
          COLLECT:  if (&seen_mask) begin
                      state    <= SCAN;
                      scan_cnt <= '0;
                    end
          SCAN: begin
            run_max  <= cand;
            scan_cnt <= scan_cnt + 1'b1;
            if (scan_cnt == IW'(N-1)) begin
              // Outputs are registered, so the decision is made on the last scan cycle
              state         <= DECIDE;
              start_q       <= 1'b1;
              vmax_q        <= 1'b1;
              winner_idx    <= cand.idx;
              won_lost_hold <= (cand.val > threshold) ? cand_onehot : '1;
            end
          end
          DECIDE:   state <= WAIT_PP3;
          WAIT_PP3: if (&done_mask) begin
                      state   <= DONE;
                      fdone_q <= 1'b1;
                    end
          DONE: begin
            spike_out <= spike_acc;
            if (|spike_acc) threshold <= th_next;
            state <= IDLE;
          end
          default:  state <= IDLE;
        endcase
      end
    end
  end

  // An abort in the pulse cycle itself must also kill the pulse that is already registered
  assign start_pp3m   = start_q & ~start_core_img;
  assign valid_maxing = vmax_q  & ~start_core_img;
  assign frame_done   = fdone_q & ~start_core_img;
endmodule

// File: tb/tb_wta_arbiter.sv
// Directed bench for wta_arbiter (N=8, W=32 defaults).
module tb_wta_arbiter;
  localparam int N = 8;
  localparam int W = 32;
  localparam int NEG = -500 * 4096;

  logic clk = 1'b0;
  logic rst, start_core_img;
  logic [N*W-1:0] potential_flat;
  logic [N-1:0] valid_pp3m, valid_pp3, spike_pp;
  logic start_pp3m, valid_maxing, frame_done;
  logic [N-1:0] won_lost_hold, spike_out;
  logic signed [W-1:0] threshold;
  logic [2:0] winner_idx;

  int n_vec = 0;
  int n_err = 0;

  wta_arbiter dut (
    .clk(clk), .rst(rst), .start_core_img(start_core_img),
    .potential_flat(potential_flat), .valid_pp3m(valid_pp3m),
    .valid_pp3(valid_pp3), .spike_pp(spike_pp), .start_pp3m(start_pp3m),
    .won_lost_hold(won_lost_hold), .valid_maxing(valid_maxing),
    .threshold(threshold), .winner_idx(winner_idx), .spike_out(spike_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run one complete frame. dcyc counts ticks from the cycle that drives the
  // last valid_pp3m bit to the DECIDE cycle. The seen_mask is full one tick
  // later, so the expected value is 1 + (N+1) = 10. The outputs sout, th and
  // fd2 are sampled one tick after frame_done.
  task automatic run_frame(input logic [N-1:0][W-1:0] p, input logic [N-1:0] spk,
                           input bit stagger, output int dcyc, output int nstart,
                           output int ndone, output logic [N-1:0] wlh,
                           output logic [2:0] widx, output logic vm,
                           output logic [N-1:0] sout, output logic [W-1:0] th,
                           output logic fd2);
    logic [N-1:0] seq [8];
    int nb, c;
    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h81};
    nb = stagger ? 8 : 1;
    if (!stagger) seq[0] = 8'hFF;
    potential_flat = p;
    dcyc = -1; nstart = 0; ndone = 0; wlh = '0; widx = '0; vm = 1'b0;
    for (int k = 0; k < nb; k++) begin
      valid_pp3m = seq[k];
      tick();
      if (start_pp3m) nstart++;
    end
    valid_pp3m = '0;
    c = 1;
    while (c < 80 && !frame_done) begin
      tick();
      c++;
      if (start_pp3m) begin
        nstart++;
        if (dcyc < 0) begin
          dcyc = c; wlh = won_lost_hold; widx = winner_idx; vm = valid_maxing;
        end
      end
      if (dcyc >= 0 && c == dcyc + 1) begin
        valid_pp3 = '1; spike_pp = spk;
      end else begin
        valid_pp3 = '0; spike_pp = '0;
      end
      if (frame_done) ndone++;
    end
    valid_pp3 = '0; spike_pp = '0;
    tick();
    sout = spike_out; th = threshold; fd2 = frame_done;
  endtask

  task automatic fill(output logic [N-1:0][W-1:0] p, input int base);
    for (int i = 0; i < N; i++) p[i] = base;
  endtask

  initial begin
    logic [N-1:0][W-1:0] p;
    int dcyc, nstart, ndone, cnt_s, cnt_d;
    logic [N-1:0] wlh, sout;
    logic [2:0] widx;
    logic vm, fd2;
    logic [W-1:0] th;

    rst = 1'b1; start_core_img = 1'b0; potential_flat = '0;
    valid_pp3m = '0; valid_pp3 = '0; spike_pp = '0;
    tick(); tick();
    chk("rst_threshold", threshold, 15019);
    chk("rst_wlh", won_lost_hold, 8'hFF);
    chk("rst_widx", winner_idx, 0);
    chk("rst_spike_out", spike_out, 0);
    chk("rst_pulses", {start_pp3m, valid_maxing, frame_done}, 0);
    rst = 1'b0;
    tick();

    // Max equal to threshold: no winner
    fill(p, 0); p[2] = 100; p[4] = 15019;
    run_frame(p, '0, 0, dcyc, nstart, ndone, wlh, widx, vm, sout, th, fd2);
    chk("tie_th_wlh", wlh, 8'hFF);
    chk("tie_th_widx", widx, 4);
    chk("tie_th_sout", sout, 0);
    chk("tie_th_threshold", th, 15019);
    chk("tie_th_done", ndone, 1);

    // Clear winner on neuron 1
    fill(p, 0); p[0] = 100; p[1] = 20000; p[2] = 5;
    run_frame(p, 8'h02, 0, dcyc, nstart, ndone, wlh, widx, vm, sout, th, fd2);
    chk("win_latency", dcyc, 10);
    chk("win_nstart", nstart, 1);
    chk("win_wlh", wlh, 8'h02);
    chk("win_widx", widx, 1);
    chk("win_valid_maxing", vm, 1);
    chk("win_done", ndone, 1);
    chk("win_sout", sout, 8'h02);
    chk("win_threshold", th, 15224);
    chk("win_done_single", fd2, 0);

    // Tie at 3 and 6, all others strongly negative
    fill(p, NEG); p[3] = 18000; p[6] = 18000;
    run_frame(p, '0, 0, dcyc, nstart, ndone, wlh, widx, vm, sout, th, fd2);
    chk("tie_widx", widx, 3);
    chk("tie_wlh", wlh, 8'h08);
    chk("tie_threshold", th, 15224);

    // All negative: argmax still signed, no winner
    fill(p, NEG); p[5] = -5; p[7] = -6;
    run_frame(p, '0, 0, dcyc, nstart, ndone, wlh, widx, vm, sout, th, fd2);
    chk("neg_widx", widx, 5);
    chk("neg_wlh", wlh, 8'hFF);

    // Staggered pp3m over 8 cycles, duplicate on neuron 0
    fill(p, NEG); p[3] = 18000; p[6] = 18000;
    run_frame(p, 8'h48, 1, dcyc, nstart, ndone, wlh, widx, vm, sout, th, fd2);
    chk("stag_latency", dcyc, 10);
    chk("stag_nstart", nstart, 1);
    chk("stag_sout", sout, 8'h48);
    chk("stag_threshold", th, 15429);

    // start_core_img during WAIT_PP3
    fill(p, 0); p[1] = 20000;
    potential_flat = p;
    valid_pp3m = '1; tick(); valid_pp3m = '0;
    cnt_s = 0;
    while (!start_pp3m && cnt_s < 40) begin tick(); cnt_s++; end
    chk("abortA_reach_decide", start_pp3m, 1);
    tick();
    valid_pp3 = 8'h0F; spike_pp = 8'h0F; tick();
    start_core_img = 1'b1; valid_pp3 = 8'hF0; spike_pp = 8'hF0;
    #1;
    chk("abortA_no_pulse", {start_pp3m, valid_maxing, frame_done}, 0);
    tick();
    start_core_img = 1'b0;
    cnt_s = 0; cnt_d = 0;
    for (int k = 0; k < 20; k++) begin
      valid_pp3 = (k % 3 == 0) ? 8'hFF : 8'h00; spike_pp = 8'hFF;
      tick();
      cnt_s += start_pp3m; cnt_d += frame_done;
    end
    valid_pp3 = '0; spike_pp = '0;
    chk("abortA_no_start", cnt_s, 0);
    chk("abortA_no_done", cnt_d, 0);
    chk("abortA_keep_sout", spike_out, 8'h48);
    chk("abortA_keep_th", threshold, 15429);
    run_frame(p, 8'h02, 0, dcyc, nstart, ndone, wlh, widx, vm, sout, th, fd2);
    chk("abortA_next_done", ndone, 1);
    chk("abortA_next_th", th, 15634);

    // rst during SCAN
    valid_pp3m = '1; tick(); valid_pp3m = '0;
    tick(); tick(); tick();
    rst = 1'b1; #1;
    chk("abortB_th", threshold, 15019);
    chk("abortB_sout", spike_out, 0);
    tick(); rst = 1'b0;
    cnt_s = 0; cnt_d = 0;
    for (int k = 0; k < 15; k++) begin
      tick(); cnt_s += start_pp3m; cnt_d += frame_done;
    end
    chk("abortB_no_pulses", cnt_s + cnt_d, 0);
    run_frame(p, 8'h02, 0, dcyc, nstart, ndone, wlh, widx, vm, sout, th, fd2);
    chk("abortB_next_wlh", wlh, 8'h02);
    chk("abortB_next_th", th, 15224);

    // Saturation: 15224 + 85*205 = 32649, next step clamps to 32768
    for (int k = 1; k <= 87; k++) begin
      run_frame(p, 8'h02, 0, dcyc, nstart, ndone, wlh, widx, vm, sout, th, fd2);
      if (k == 85) chk("sat_below", th, 32649);
      if (k == 86) chk("sat_clamp", th, 32768);
      if (k == 87) chk("sat_hold", th, 32768);
    end
    chk("sat_last_done", ndone, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
